// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman output path (bit-concatenation stage and
// byte serializer).
package huff_pkg;

  localparam int BYTE_W = 8;

  localparam logic SH_EMPTY_ENC = 1'b0;
  localparam logic SH_SHIFT_ENC = 1'b1;

  typedef enum logic {
    SH_EMPTY = SH_EMPTY_ENC,
    SH_SHIFT = SH_SHIFT_ENC
  } sh_state_e;

  // Number of bytes needed to carry the given number of bits.
  function automatic int unsigned ceil_div8(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/huff_word_fifo.sv
// Small synchronous word FIFO. The head entry is readable combinationally so
// the serializer can pop and load it in the same cycle.
module huff_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/huff_byte_serializer.sv
// Buffers Huffman concat-stage words and streams them out MSB-first as bytes
// over valid/ready; a final partial word emits only its ceil(len/8) bytes.
module huff_byte_serializer
  import huff_pkg::*;
#(
  parameter int OUT_WIDTH  = 128,
  parameter int FIFO_DEPTH = 4,
  localparam int LEN_W     = $clog2(OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 word_valid,
  input  logic [OUT_WIDTH-1:0] word_data,
  input  logic                 word_last,
  input  logic [LEN_W-1:0]     word_len,
  output logic                 almost_full,
  output logic                 overflow_err,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [2:0]           m_bits
);

  localparam int ENTRY_W = OUT_WIDTH + 1 + LEN_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int BCNT_W  = $clog2(OUT_WIDTH / BYTE_W + 1);
  localparam int L_W     = LEN_W + 1;
  localparam logic [L_W-1:0]    FULL_LEN   = L_W'(OUT_WIDTH);
  localparam logic [BCNT_W-1:0] WORD_BYTES = BCNT_W'(OUT_WIDTH / BYTE_W);

  logic [ENTRY_W-1:0]   fifo_dout;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push_en;
  logic                 pop_en;
  logic [CNT_W-1:0]     next_count;

  logic [OUT_WIDTH-1:0] head_data;
  logic                 head_last;
  logic [LEN_W-1:0]     head_len;
  logic [L_W-1:0]       head_l;

  sh_state_e            state_q, state_d;
  logic [OUT_WIDTH-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic                 last_q, last_d;
  logic [2:0]           bits_q, bits_d;

  logic                 m_valid_q, m_valid_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 m_last_q, m_last_d;
  logic [2:0]           m_bits_q, m_bits_d;
  logic                 almost_full_q, almost_full_d;
  logic                 overflow_q, overflow_d;

  logic                 out_free;
  logic                 advance;
  logic                 final_byte;

  huff_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (word_valid),
    .pop   (pop_en),
    .din   ({word_data, word_last, word_len}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_data = fifo_dout[ENTRY_W-1 -: OUT_WIDTH];
  assign head_last = fifo_dout[LEN_W];
  assign head_len  = fifo_dout[LEN_W-1:0];
  assign head_l    = (head_len == '0) ? FULL_LEN : {1'b0, head_len};

  // Bytes leave through an output register; the shifter advances whenever
  // that register is empty or being drained, so throughput stays 1 byte/cycle.
  assign out_free   = !m_valid_q || m_ready;
  assign advance    = (state_q == SH_SHIFT) && out_free;
  assign final_byte = (byte_cnt_q == BCNT_W'(1));
  assign push_en    = word_valid && !fifo_full;
  assign pop_en     = !fifo_empty && ((state_q == SH_EMPTY) || (advance && final_byte));

  always_comb begin
    case ({push_en, pop_en})
      2'b10:   next_count = fifo_count + CNT_W'(1);
      2'b01:   next_count = fifo_count - CNT_W'(1);
      default: next_count = fifo_count;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    byte_cnt_d    = byte_cnt_q;
    last_d        = last_q;
    bits_d        = bits_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    m_bits_d      = m_bits_q;
    almost_full_d = (next_count >= CNT_W'(FIFO_DEPTH - 1));
    overflow_d    = overflow_q || (word_valid && fifo_full);

    if (out_free) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      m_bits_d  = '0;
    end

    if (advance) begin
      m_valid_d  = 1'b1;
      m_data_d   = shift_q[OUT_WIDTH-1 -: BYTE_W];
      m_last_d   = last_q && final_byte;
      m_bits_d   = (last_q && final_byte) ? bits_q : 3'd0;
      shift_d    = shift_q << BYTE_W;
      byte_cnt_d = byte_cnt_q - BCNT_W'(1);
      if (final_byte) state_d = SH_EMPTY;
    end

    // A final word is left-justified so its first valid bit leads the byte.
    if (pop_en) begin
      state_d = SH_SHIFT;
      if (head_last) begin
        shift_d    = head_data << (FULL_LEN - head_l);
        byte_cnt_d = BCNT_W'(ceil_div8(32'(head_l)));
        last_d     = 1'b1;
        bits_d     = head_l[2:0];
      end else begin
        shift_d    = head_data;
        byte_cnt_d = WORD_BYTES;
        last_d     = 1'b0;
        bits_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SH_EMPTY;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      last_q        <= 1'b0;
      bits_q        <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      m_bits_q      <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      byte_cnt_q    <= byte_cnt_d;
      last_q        <= last_d;
      bits_q        <= bits_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      m_bits_q      <= m_bits_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign m_bits       = m_bits_q;
  assign almost_full  = almost_full_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_huff_byte_serializer.sv
// Directed self-checking bench for huff_byte_serializer with 16-bit words and
// a 4-entry FIFO.
module tb_huff_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        word_valid = 1'b0;
  logic [15:0] word_data = '0;
  logic        word_last = 1'b0;
  logic [3:0]  word_len = '0;
  logic        m_ready = 1'b0;
  logic        almost_full;
  logic        overflow_err;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic [2:0]  m_bits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  huff_byte_serializer #(
    .OUT_WIDTH  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_last    (word_last),
    .word_len     (word_len),
    .almost_full  (almost_full),
    .overflow_err (overflow_err),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .m_bits       (m_bits)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, input logic l, input logic [3:0] n);
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    word_len   = n;
    step();
    word_valid = 1'b0;
    word_last  = 1'b0;
    word_len   = '0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (m_bits !== 3'd0) begin errors++; $display("FAIL reset_m_bits: got %0d want 0", m_bits); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", m_valid); end
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    push_word(16'hABCD, 1'b0, 4'd0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: got valid %b want 0", m_valid); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_lat2: got valid %b want 0", m_valid); end
    step();
    $display("tx basic byte0 data=%h last=%b", m_data, m_last);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hAB || m_last !== 1'b0)
      begin errors++; $display("FAIL basic_b0: got v=%b d=%h l=%b want v=1 d=ab l=0", m_valid, m_data, m_last); end
    step();
    $display("tx basic byte1 data=%h last=%b", m_data, m_last);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hCD || m_last !== 1'b0)
      begin errors++; $display("FAIL basic_b1: got v=%b d=%h l=%b want v=1 d=cd l=0", m_valid, m_data, m_last); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_end: got valid %b want 0", m_valid); end
  endtask

  task automatic test_final_word();
    m_ready = 1'b1;
    push_word(16'h002D, 1'b1, 4'd6);
    step();
    step();
    $display("tx final byte data=%h last=%b bits=%0d", m_data, m_last, m_bits);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hB4)
      begin errors++; $display("FAIL final_data: got v=%b d=%h want v=1 d=b4", m_valid, m_data); end
    checks++; if (m_last !== 1'b1 || m_bits !== 3'd6)
      begin errors++; $display("FAIL final_last: got l=%b bits=%0d want l=1 bits=6", m_last, m_bits); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL final_end: got valid %b want 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    m_ready    = 1'b1;
    word_valid = 1'b1;
    word_data  = 16'h1234;
    word_last  = 1'b0;
    word_len   = 4'd0;
    step();
    word_data  = 16'h0005;
    word_last  = 1'b1;
    word_len   = 4'd3;
    step();
    word_valid = 1'b0;
    word_last  = 1'b0;
    word_len   = 4'd0;
    step();
    $display("tx b2b byte0 data=%h last=%b", m_data, m_last);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h12 || m_last !== 1'b0)
      begin errors++; $display("FAIL b2b_b0: got v=%b d=%h l=%b want v=1 d=12 l=0", m_valid, m_data, m_last); end
    step();
    $display("tx b2b byte1 data=%h last=%b", m_data, m_last);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h34 || m_last !== 1'b0 || m_bits !== 3'd0)
      begin errors++; $display("FAIL b2b_b1: got v=%b d=%h l=%b bits=%0d want v=1 d=34 l=0 bits=0", m_valid, m_data, m_last, m_bits); end
    step();
    $display("tx b2b byte2 data=%h last=%b bits=%0d", m_data, m_last, m_bits);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hA0 || m_last !== 1'b1 || m_bits !== 3'd3)
      begin errors++; $display("FAIL b2b_b2: got v=%b d=%h l=%b bits=%0d want v=1 d=a0 l=1 bits=3", m_valid, m_data, m_last, m_bits); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got valid %b want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] wd [8] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708,
                            16'h090A, 16'h0B0C, 16'h0D0E, 16'h0007};
    logic [7:0]  eb [15] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                             8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'hE0};
    int          wi = 0;
    int          bi = 0;
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    while (bi < 15 && cyc < 400) begin
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data)
          begin errors++; $display("FAIL bp_stall_hold: got v=%b d=%h want v=1 d=%h", m_valid, m_data, prev_data); end
      end
      word_valid = 1'b0;
      word_last  = 1'b0;
      word_len   = 4'd0;
      if (wi < 8 && !almost_full && $urandom_range(0, 1) == 1) begin
        word_valid = 1'b1;
        word_data  = wd[wi];
        word_last  = (wi == 7);
        word_len   = (wi == 7) ? 4'd3 : 4'd0;
        wi++;
      end
      m_ready = ($urandom_range(0, 1) == 1);
      if (m_valid && m_ready) begin
        $display("tx bp byte%0d data=%h last=%b", bi, m_data, m_last);
        checks++;
        if (m_data !== eb[bi] || m_last !== (bi == 14))
          begin errors++; $display("FAIL bp_byte%0d: got d=%h l=%b want d=%h l=%b", bi, m_data, m_last, eb[bi], (bi == 14)); end
        bi++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      step();
      cyc++;
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
    word_len   = 4'd0;
    m_ready    = 1'b0;
    checks++; if (bi != 15) begin errors++; $display("FAIL bp_timeout: got %0d bytes want 15", bi); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_end: got valid %b want 0", m_valid); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %b want 0", overflow_err); end
  endtask

  task automatic test_overflow();
    logic [15:0] ow [5] = '{16'h2122, 16'h3132, 16'h4142, 16'h5152, 16'h6162};
    logic        exp_af [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        exp_ov [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0]  eb [10] = '{8'h11, 8'h11, 8'h21, 8'h22, 8'h31, 8'h32, 8'h41, 8'h42, 8'h51, 8'h52};
    int          bi = 0;
    m_ready = 1'b0;
    push_word(16'h1111, 1'b0, 4'd0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      word_valid = 1'b1;
      word_data  = ow[i];
      step();
      word_valid = 1'b0;
      checks++; if (almost_full !== exp_af[i])
        begin errors++; $display("FAIL ovf_af_push%0d: got %b want %b", i + 1, almost_full, exp_af[i]); end
      checks++; if (overflow_err !== exp_ov[i])
        begin errors++; $display("FAIL ovf_err_push%0d: got %b want %b", i + 1, overflow_err, exp_ov[i]); end
    end
    repeat (3) step();
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    m_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (m_valid && m_ready) begin
        $display("tx ovf byte%0d data=%h", bi, m_data);
        checks++;
        if (bi >= 10) begin
          errors++; $display("FAIL ovf_extra_byte: got d=%h want no byte", m_data);
        end else if (m_data !== eb[bi]) begin
          errors++; $display("FAIL ovf_byte%0d: got %h want %h", bi, m_data, eb[bi]);
        end
        bi++;
      end
      step();
    end
    checks++; if (bi != 10) begin errors++; $display("FAIL ovf_count: got %0d bytes want 10", bi); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky_drain: got %b want 1", overflow_err); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL ovf_af_drain: got %b want 0", almost_full); end
  endtask

  task automatic test_mid_reset();
    m_ready = 1'b0;
    push_word(16'hABCD, 1'b0, 4'd0);
    step();
    step();
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hAB)
      begin errors++; $display("FAIL mrst_first: got v=%b d=%h want v=1 d=ab", m_valid, m_data); end
    m_ready = 1'b1;
    step();
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hCD)
      begin errors++; $display("FAIL mrst_second: got v=%b d=%h want v=1 d=cd", m_valid, m_data); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mrst_async_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL mrst_async_data: got %h want 00", m_data); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL mrst_async_ovf: got %b want 0", overflow_err); end
    #4 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mrst_quiet%0d: got valid %b want 0", c, m_valid); end
    end
    push_word(16'h5A3C, 1'b0, 4'd0);
    step();
    step();
    $display("tx mrst byte0 data=%h", m_data);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A)
      begin errors++; $display("FAIL mrst_new_b0: got v=%b d=%h want v=1 d=5a", m_valid, m_data); end
    step();
    $display("tx mrst byte1 data=%h", m_data);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h3C)
      begin errors++; $display("FAIL mrst_new_b1: got v=%b d=%h want v=1 d=3c", m_valid, m_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_final_word();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
